serial_sync_fifo: RTL and testbench
===================================

// Module: serial_sync_fifo
// PURPOSE
//  Parametrised successor to the single-word serial synchronizer. Brings an
//  asynchronous data-ready strobe into the clk domain through a SYNC_STAGES
//  flop chain and captures the qualifying word on each synchronized rising
//  edge. Captured words are buffered in a FIFO_DEPTH-entry FIFO and presented
//  downstream on a valid/ready handshake, with overflow detection.
//  Sits between the serial receiver (foreign domain) and the packet logic.
// PARAMETERS
//  DATA_WIDTH   32  width of i_data / o_data
//  SYNC_STAGES  2   synchronizer flops on asyn_data_ready; legal values >= 2
//  FIFO_DEPTH   4   buffer entries; power of 2, >= 2
//  CNT_W        $clog2(FIFO_DEPTH)+1  localparam; width of o_count
// PORTS
//  clk              in   1           single clock; all state on posedge
//  rst              in   1           asynchronous, active-low reset
//  asyn_data_ready  in   1           async strobe; i_data is valid while it is high
//  i_data           in   DATA_WIDTH  async data; source holds it stable from strobe rise to fall
//  o_data           out  DATA_WIDTH  FIFO head word; meaningful only when o_valid=1
//  o_valid          out  1           FIFO not empty
//  o_ready          in   1           consumer accepts head when o_valid & o_ready
//  o_count          out  CNT_W       number of words buffered, 0..FIFO_DEPTH
//  o_overflow       out  1           sticky: a captured word was dropped because the FIFO was full
//  ovf_clr          in   1           synchronous clear of o_overflow
// BEHAVIOUR
//  - Reset (rst=0, async): sync chain, armed flag, pointers, count and
//    o_overflow all clear to 0; o_valid=0, o_data=0, o_count=0.
//  - Sync: sync[0] <= asyn_data_ready; sync[i] <= sync[i-1]; s = sync[LAST].
//  - Armed flag: set on the first cycle with s=0 after reset. No capture is
//    made while unarmed. A strobe already high at reset release is ignored
//    until it is seen low once.
//  - Capture (push): on the cycle where armed & s & !s_d (s_d = s delayed by
//    one flop), write i_data into the tail entry. There is exactly one push
//    per strobe, whatever the strobe length. Back-to-back strobes need at
//    least one low sample at s.
//  - Latency: strobe rise sampled at edge k -> push at edge k+SYNC_STAGES ->
//    o_valid=1 after edge k+SYNC_STAGES+1 (FIFO was empty). There is no
//    empty-FIFO bypass.
//  - Pop: on the cycle where o_valid & o_ready, advance the head. o_data shows
//    the new head, or holds its last value when the FIFO becomes empty.
//  - Push while full and no pop: the word is dropped, o_overflow is set, and
//    the FIFO contents are unchanged.
//  - Push while full with a simultaneous pop: both happen; no overflow; count
//    is unchanged.
//  - Push while empty with o_ready=1: no pop that cycle (o_valid=0); count
//    goes to 1.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The
//    full/empty decision comes from o_count, never from pointer equality.
//  - ovf_clr: clears o_overflow next edge. If it coincides with a new
//    overflow event, set wins (o_overflow stays 1).
//  - Reset mid-operation: buffered words are discarded and the armed flag is
//    cleared, so a strobe in flight is not captured.
//  - o_ready is ignored while o_valid=0. There are no combinational paths
//    from inputs to outputs.
// TESTING
//  1 Reset release with asyn_data_ready held high for 10 cycles, then low ->
//    no push, o_count=0; next strobe with i_data=32'hCAFE0001 -> o_data=32'hCAFE0001,
//    o_valid high 3 cycles after rise (SYNC_STAGES=2).
//  2 Strobe held high for 20 cycles with o_ready=0 -> o_count=1 exactly
//    (single capture per strobe).
//  3 Five strobes (data 1..5), o_ready=0, DEPTH=4 -> o_count=4,
//    o_overflow=1; drain yields 1,2,3,4 in order; pulse ovf_clr -> o_overflow=0.
//  4 FIFO full, push and pop on the same cycle -> o_overflow stays 0,
//    o_count stays 4, order preserved across pointer wrap (>= 3 wraps).
//  5 rst asserted while o_count=2 and a strobe is mid-sync -> all outputs 0
//    immediately; after release, that strobe produces no push.
//  6 Random strobe spacing (>= 2*SYNC_STAGES low cycles) and random o_ready
//    over 1000 words -> scoreboard match, no overflow when consumption keeps pace.

Source files
------------

// File: rtl/serial_sync_fifo.sv
// serial_sync_fifo: brings an asynchronous data-ready strobe into the clk
// domain, captures one word per synchronized rising edge and buffers the
// captured words in a small FIFO with a valid/ready output and a sticky
// overflow flag.
module serial_sync_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  asyn_data_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_overflow,
    input  logic                  ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Synchronizer and edge detection
    logic [SYNC_STAGES-1:0] sync_reg;
    // fill_reg tracks which sync stages hold a genuine post-reset sample,
    // so the reset value of the chain is never mistaken for a low strobe.
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   s_d_reg;
    logic                   armed_reg;
    logic                   s;
    logic                   capture;

    // One-word capture stage between the edge detector and the FIFO write
    logic                   cap_valid_reg;
    logic [DATA_WIDTH-1:0]  cap_data_reg;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_inc;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [DATA_WIDTH-1:0]  data_next;
    logic                   overflow_reg;

    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   ovf_evt;

    assign s          = sync_reg[SYNC_STAGES-1];
    assign capture    = armed_reg & s & ~s_d_reg;
    assign pop        = (count_reg != '0) & o_ready;
    assign full       = (count_reg == FULL_CNT);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign wr_en      = cap_valid_reg & (~full | pop);
    assign ovf_evt    = cap_valid_reg & full & ~pop;
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    // Synchronizer chain, edge-detect delay and arming flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg  <= '0;
            fill_reg  <= '0;
            s_d_reg   <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], asyn_data_ready};
            fill_reg  <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
            s_d_reg   <= s;
            armed_reg <= armed_reg | (fill_reg[SYNC_STAGES-1] & ~s);
        end
    end

    // Capture register: holds the word taken on the synchronized rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid_reg <= 1'b0;
            cap_data_reg  <= '0;
        end else begin
            cap_valid_reg <= capture;
            if (capture) begin
                cap_data_reg <= i_data;
            end
        end
    end

    // Storage write port (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= cap_data_reg;
        end
    end

    // Next count and next head word
    always_comb begin
        count_next = count_reg;
        data_next  = data_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + ONE_CNT;
        end else if (!wr_en && pop) begin
            count_next = count_reg - ONE_CNT;
        end
        // The incoming word becomes the head when the FIFO is, or is about
        // to become, empty; otherwise a pop loads the next stored entry.
        if (wr_en && ((count_reg == '0) || ((count_reg == ONE_CNT) && pop))) begin
            data_next = cap_data_reg;
        end else if (pop && (count_reg > ONE_CNT)) begin
            data_next = mem[rd_ptr_inc];
        end
    end

    // Pointers, count, registered head word and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg    <= count_next;
            data_reg     <= data_next;
            // A new overflow outranks a simultaneous clear.
            overflow_reg <= (overflow_reg & ~ovf_clr) | ovf_evt;
        end
    end

    assign o_data     = data_reg;
    assign o_valid    = (count_reg != '0);
    assign o_count    = count_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_serial_sync_fifo.sv
// Directed and random checks of serial_sync_fifo against a queue scoreboard.
module tb_serial_sync_fifo;

    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          asyn_data_ready;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          ovf_clr;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   q[$];

    serial_sync_fifo #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .asyn_data_ready(asyn_data_ready),
        .i_data         (i_data),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .ovf_clr        (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already set; if a pop will happen on the coming edge,
    // compare the head against the scoreboard, then advance one cycle.
    task automatic cyc();
        logic [31:0] exp_word;
        if (o_valid === 1'b1 && o_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("pop_unexpected", {31'b0, o_valid}, 32'd0);
            end else begin
                exp_word = q.pop_front();
                check("pop_data", o_data, exp_word);
                $display("pop  data=%h", o_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic strobe(input logic [31:0] d, input int hi, input int lo, input bit expect_push);
        i_data          = d;
        asyn_data_ready = 1'b1;
        if (expect_push) q.push_back(d);
        $display("strobe data=%h hi=%0d lo=%0d expect_push=%0d", d, hi, lo, expect_push);
        repeat (hi) cyc();
        asyn_data_ready = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic drain();
        o_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cyc();
        check("drain_left", q.size(), 32'd0);
        o_ready = 1'b0;
        cyc();
        check("drain_count", {29'b0, o_count}, 32'd0);
        check("drain_valid", {31'b0, o_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          hi;
        int          lo;

        rst             = 1'b0;
        asyn_data_ready = 1'b1;
        i_data          = 32'h0;
        o_ready         = 1'b0;
        ovf_clr         = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_count", {29'b0, o_count}, 32'd0);
        check("rst_ovf", {31'b0, o_overflow}, 32'd0);

        // Test 1: strobe high across reset release is ignored
        rst = 1'b1;
        repeat (10) cyc();
        check("t1_held_count", {29'b0, o_count}, 32'd0);
        asyn_data_ready = 1'b0;
        repeat (6) cyc();
        check("t1_low_count", {29'b0, o_count}, 32'd0);
        check("t1_low_valid", {31'b0, o_valid}, 32'd0);

        // Test 1: latency of a fresh strobe
        i_data          = 32'hCAFE0001;
        asyn_data_ready = 1'b1;
        q.push_back(32'hCAFE0001);
        cyc(); cyc(); cyc();
        check("t1_valid_early", {31'b0, o_valid}, 32'd0);
        cyc();
        check("t1_valid_3cyc", {31'b0, o_valid}, 32'd1);
        check("t1_data", o_data, 32'hCAFE0001);
        asyn_data_ready = 1'b0;
        repeat (4) cyc();
        drain();

        // Test 2: long strobe gives exactly one capture
        strobe(32'hA5A50002, 20, 6, 1'b1);
        check("t2_count", {29'b0, o_count}, 32'd1);
        drain();

        // Test 3: overflow on the fifth word, drain order, clear
        for (int k = 1; k <= 5; k++) strobe(32'(k), 3, 4, k <= 4);
        check("t3_count", {29'b0, o_count}, 32'd4);
        check("t3_ovf", {31'b0, o_overflow}, 32'd1);
        drain();
        check("t3_ovf_sticky", {31'b0, o_overflow}, 32'd1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'b0, o_overflow}, 32'd0);

        // Test 4: full FIFO with simultaneous push and pop, across wraps
        for (int k = 0; k < 4; k++) strobe(32'h40000000 + 32'(k), 3, 4, 1'b1);
        check("t4_full", {29'b0, o_count}, 32'd4);
        for (int r = 0; r < 14; r++) begin
            d               = 32'h44000000 + 32'(r);
            i_data          = d;
            asyn_data_ready = 1'b1;
            q.push_back(d);
            $display("strobe data=%h push+pop at full", d);
            cyc(); cyc(); cyc();
            o_ready = 1'b1;
            cyc();
            o_ready = 1'b0;
            check("t4_count", {29'b0, o_count}, 32'd4);
            check("t4_ovf", {31'b0, o_overflow}, 32'd0);
            asyn_data_ready = 1'b0;
            repeat (4) cyc();
        end
        drain();

        // Test 5: reset mid-operation with a strobe in the synchronizer
        strobe(32'h50000001, 3, 4, 1'b1);
        strobe(32'h50000002, 3, 4, 1'b1);
        check("t5_count2", {29'b0, o_count}, 32'd2);
        i_data          = 32'hDEAD0005;
        asyn_data_ready = 1'b1;
        cyc();
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, o_valid}, 32'd0);
        check("t5_rst_data", o_data, 32'd0);
        check("t5_rst_count", {29'b0, o_count}, 32'd0);
        check("t5_rst_ovf", {31'b0, o_overflow}, 32'd0);
        q.delete();
        @(negedge clk);
        cyc();
        rst = 1'b1;
        repeat (6) cyc();
        asyn_data_ready = 1'b0;
        repeat (8) cyc();
        check("t5_no_push", {29'b0, o_count}, 32'd0);
        // Push into an empty FIFO while o_ready is already high
        o_ready = 1'b1;
        strobe(32'hBEEF0006, 2, 6, 1'b1);
        check("t5_after_count", {29'b0, o_count}, 32'd0);
        check("t5_after_q", q.size(), 32'd0);
        o_ready = 1'b0;

        // Test 6: random spacing and random consumer
        for (int w = 0; w < 1000; w++) begin
            d               = $urandom;
            hi              = $urandom_range(1, 3);
            lo              = $urandom_range(4, 8);
            i_data          = d;
            asyn_data_ready = 1'b1;
            q.push_back(d);
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) asyn_data_ready = 1'b0;
                o_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
        end
        check("t6_ovf", {31'b0, o_overflow}, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
